// File: rtl/bdd_pkg.sv
// Shared constants and types for the BDD traversal front end.
package bdd_pkg;

  localparam int unsigned FEAT_W = 8;               // one feature / coefficient
  localparam int unsigned N_FEAT = 5;               // features per vector (a1..a5)
  localparam int unsigned VEC_W  = N_FEAT * FEAT_W; // packed vector, a1 in MSBs
  localparam int unsigned TAG_W  = 8;               // vector sequence tag

  typedef logic [VEC_W-1:0] feat_vec_t;

  // Assembly state: collecting a vector, or swallowing the tail of an overlong one
  typedef enum logic {
    StFill = 1'b0,
    StDrop = 1'b1
  } asm_state_t;

endpackage

// File: rtl/bdd_vec_fifo.sv
// Generic synchronous show-ahead FIFO with explicit occupancy counter.
// The head entry is visible on rdata whenever the FIFO is non-empty; rdata is 0 when empty.
module bdd_vec_fifo #(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             do_push;
  logic             do_pop;

  // Handshake qualification and show-ahead read port
  always_comb begin
    full    = (level_q == LVL_W'(DEPTH));
    empty   = (level_q == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    rdata   = empty ? '0 : mem_q[rd_ptr_q];
    level   = level_q;
  end

  // Pointers wrap modulo DEPTH; level tracks occupancy separately
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop) begin
        level_q <= level_q + LVL_W'(1);
      end else if (!do_push && do_pop) begin
        level_q <= level_q - LVL_W'(1);
      end
    end
  end

  // Storage needs no reset: reads are masked while empty
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/bdd_feature_loader.sv
// Feature loader: assembles byte stream into 5-feature vectors and queues them for the
// traversal engine. Optional build macro BDD_VEC_TAG_EN adds an 8-bit sequence tag per vector.
module bdd_feature_loader
  import bdd_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     s_valid,
  input  logic [FEAT_W-1:0]        s_data,
  input  logic                     s_last,
  output logic                     s_ready,
  output logic                     vec_valid,
  output logic [VEC_W-1:0]         vec_data,
  input  logic                     vec_ready,
  output logic                     err_len,
  output logic [$clog2(DEPTH):0]   level
`ifdef BDD_VEC_TAG_EN
  ,
  output logic [TAG_W-1:0]         vec_tag
`endif
);

  localparam int unsigned IDX_W  = $clog2(N_FEAT);
  localparam int unsigned PART_W = (N_FEAT - 1) * FEAT_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);
`ifdef BDD_VEC_TAG_EN
  localparam int unsigned FIFO_W = VEC_W + TAG_W;
`else
  localparam int unsigned FIFO_W = VEC_W;
`endif

  asm_state_t        state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [PART_W-1:0] part_q;   // a1..a(N-1), a1 ends up in MSBs
  logic              err_q;
  logic              byte_xfer;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  feat_vec_t         push_vec;
  logic [FIFO_W-1:0] fifo_wdata;
  logic [FIFO_W-1:0] fifo_rdata;

  // Byte acceptance depends only on registered state, never on vec_ready
  always_comb begin
    s_ready   = (state_q == StDrop) || !((idx_q == LAST_IDX) && fifo_full);
    byte_xfer = s_valid && s_ready && !flush;
    fifo_push = byte_xfer && (state_q == StFill) && (idx_q == LAST_IDX) && s_last;
    fifo_pop  = vec_ready && !flush;
    push_vec  = {part_q, s_data};
  end

  // Assembly FSM: shift in features, discard short/long vectors with one err pulse
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q <= StFill;
      idx_q   <= '0;
      part_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (byte_xfer) begin
        case (state_q)
          StFill: begin
            if (idx_q == LAST_IDX) begin
              idx_q <= '0;
              if (!s_last) begin
                err_q   <= 1'b1;
                state_q <= StDrop;
              end
            end else if (s_last) begin
              idx_q <= '0;
              err_q <= 1'b1;
            end else begin
              part_q <= {part_q[PART_W-FEAT_W-1:0], s_data};
              idx_q  <= idx_q + IDX_W'(1);
            end
          end
          StDrop: begin
            if (s_last) state_q <= StFill;
          end
          default: state_q <= StFill;
        endcase
      end
    end
  end

`ifdef BDD_VEC_TAG_EN
  logic [TAG_W-1:0] tag_q;

  // Tag advances only for vectors that actually enter the FIFO
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      tag_q <= '0;
    end else if (fifo_push) begin
      tag_q <= tag_q + TAG_W'(1);
    end
  end

  // Tag rides in the upper bits of each FIFO entry
  always_comb begin
    fifo_wdata = {tag_q, push_vec};
    vec_tag    = fifo_rdata[FIFO_W-1 -: TAG_W];
  end
`else
  // Untagged build: FIFO carries the vector only
  always_comb begin
    fifo_wdata = push_vec;
  end
`endif

  bdd_vec_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Output view of the FIFO head
  always_comb begin
    vec_valid = !fifo_empty;
    vec_data  = fifo_rdata[VEC_W-1:0];
    err_len   = err_q;
  end

endmodule

// File: tb/tb_bdd_feature_loader.sv
// Bench for bdd_feature_loader: directed scenarios plus random traffic, checked every cycle
// against a queue-based reference model. Tag checks are active when BDD_VEC_TAG_EN is defined.
module tb_bdd_feature_loader;
  import bdd_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              s_valid;
  logic [FEAT_W-1:0] s_data;
  logic              s_last;
  logic              s_ready;
  logic              vec_valid;
  logic [VEC_W-1:0]  vec_data;
  logic              vec_ready;
  logic              err_len;
  logic [LVL_W-1:0]  level;
`ifdef BDD_VEC_TAG_EN
  logic [TAG_W-1:0]  vec_tag;
`endif

  bdd_feature_loader #(
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .vec_valid (vec_valid),
    .vec_data  (vec_data),
    .vec_ready (vec_ready),
    .err_len   (err_len),
    .level     (level)
`ifdef BDD_VEC_TAG_EN
    ,
    .vec_tag   (vec_tag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int err_pulses = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected FIFO contents as a queue, bytes of the vector in progress
  typedef struct {
    logic [VEC_W-1:0] vec;
    logic [7:0]       tag;
  } exp_t;

  exp_t             sb[$];
  logic [7:0]       cur[$];
  bit               dropping = 0;
  bit               err_exp = 0;
  int               m_tag = 0;
  logic             m_sready;
  logic [VEC_W-1:0] m_head;
  logic [VEC_W-1:0] m_vec;
  exp_t             m_new;

  // Monitor: compare DUT against model, then advance model by the coming edge
  always @(negedge clk) begin
    m_sready = dropping || !((cur.size() == N_FEAT - 1) && (sb.size() == DEPTH));
    m_head   = (sb.size() != 0) ? sb[0].vec : '0;
    check("err_len", 64'(err_len), 64'(err_exp));
    check("level", 64'(level), 64'(sb.size()));
    check("vec_valid", 64'(vec_valid), 64'(sb.size() != 0));
    check("vec_data", 64'(vec_data), 64'(m_head));
    check("s_ready", 64'(s_ready), 64'(m_sready));
`ifdef BDD_VEC_TAG_EN
    check("vec_tag", 64'(vec_tag), (sb.size() != 0) ? 64'(sb[0].tag) : 64'd0);
`endif
    if (err_len === 1'b1) err_pulses++;

    if (rst || flush) begin
      sb.delete();
      cur.delete();
      dropping = 0;
      err_exp  = 0;
      m_tag    = 0;
    end else begin
      err_exp = 0;
      if (vec_ready && sb.size() != 0) sb.delete(0);
      if (s_valid && m_sready) begin
        if (dropping) begin
          if (s_last) dropping = 0;
        end else begin
          cur.push_back(s_data);
          if (s_last) begin
            if (cur.size() == N_FEAT) begin
              m_vec = '0;
              foreach (cur[i]) m_vec = m_vec * 256 + VEC_W'(cur[i]);
              m_new.vec = m_vec;
              m_new.tag = 8'(m_tag);
              m_tag = (m_tag + 1) % 256;
              sb.push_back(m_new);
            end else begin
              err_exp = 1;
            end
            cur.delete();
          end else if (cur.size() == N_FEAT) begin
            err_exp  = 1;
            dropping = 1;
            cur.delete();
          end
        end
      end
    end
  end

  // Drive one byte and hold it until accepted (bounded)
  task automatic send_byte(input logic [7:0] d, input logic last);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (s_ready === 1'b1 && !flush && !rst) break;
    end
    if (n == 100) begin
      checks++;
      errors++;
      $display("FAIL send_byte: timeout waiting for s_ready, byte %0h", d);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_vec5(input logic [VEC_W-1:0] v);
    for (int i = 0; i < N_FEAT; i++) send_byte(v[VEC_W-1-8*i -: 8], i == N_FEAT - 1);
  endtask

  task automatic send_len(input int n, input logic [7:0] start);
    for (int i = 0; i < n; i++) send_byte(start + 8'(i), i == n - 1);
  endtask

  task automatic drain();
    vec_ready = 1'b1;
    repeat (DEPTH + 2) @(posedge clk);
    #1;
    vec_ready = 1'b0;
  endtask

  logic [7:0] pend[$];
  int         len;
  int         base;
  logic [7:0] rb;

  initial begin
    rst = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; vec_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_vec_valid", 64'(vec_valid), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd1);
    check("rst_err_len", 64'(err_len), 64'd0);
    check("rst_vec_data", 64'(vec_data), 64'd0);
    @(posedge clk);
    #1;

    // Basic assembly and one-cycle visibility
    send_vec5(40'h1122334455);
    @(negedge clk);
    check("t1_vec_valid", 64'(vec_valid), 64'd1);
    check("t1_vec_data", 64'(vec_data), 64'h1122334455);
    check("t1_level", 64'(level), 64'd1);
    check("t1_no_err", 64'(err_pulses), 64'd0);
    @(posedge clk);
    #1;
    drain();

    // Short then long vector, then a good one
    base = err_pulses;
    send_len(3, 8'hA0);
    repeat (2) @(negedge clk);
    check("t2_short_err", 64'(err_pulses - base), 64'd1);
    check("t2_short_level", 64'(level), 64'd0);
    @(posedge clk);
    #1;
    base = err_pulses;
    send_len(7, 8'hB0);
    repeat (2) @(negedge clk);
    check("t2_long_err", 64'(err_pulses - base), 64'd1);
    @(posedge clk);
    #1;
    send_vec5(40'h0102030405);
    @(negedge clk);
    check("t2_good_vec", 64'(vec_data), 64'h0102030405);
    @(posedge clk);
    #1;
    drain();

    // Backpressure: fill to DEPTH, fifth final byte stalls until one pop
    for (int k = 1; k <= 4; k++) send_vec5({5{8'(k)}});
    for (int i = 0; i < N_FEAT - 1; i++) send_byte(8'h05, 1'b0);
    fork
      send_byte(8'h05, 1'b1);
      begin
        @(negedge clk);
        check("t3_stall", 64'(s_ready), 64'd0);
        check("t3_full", 64'(level), 64'd4);
        @(posedge clk);
        #1 vec_ready = 1'b1;
        @(posedge clk);
        #1 vec_ready = 1'b0;
      end
    join
    @(negedge clk);
    check("t3_refill", 64'(level), 64'd4);
    check("t3_head2", 64'(vec_data), {24'd0, 40'h0202020202});
    @(posedge clk);
    #1;
    drain();

    // Simultaneous push/pop at level 1
    send_vec5(40'hC1C2C3C4C5);
    for (int i = 0; i < N_FEAT - 1; i++) send_byte(8'hD1 + 8'(i), 1'b0);
    vec_ready = 1'b1;
    send_byte(8'hD5, 1'b1);
    vec_ready = 1'b0;
    @(negedge clk);
    check("t4_level", 64'(level), 64'd1);
    check("t4_head", 64'(vec_data), 64'hD1D2D3D4D5);
    @(posedge clk);
    #1;
    drain();

    // Flush, then reset, mid-vector with level 2
    for (int r = 0; r < 2; r++) begin
      send_vec5(40'h1010101010);
      send_vec5(40'h2020202020);
      send_byte(8'h77, 1'b0);
      send_byte(8'h78, 1'b0);
      if (r == 0) flush = 1'b1; else rst = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      rst   = 1'b0;
      @(negedge clk);
      check("t5_level", 64'(level), 64'd0);
      check("t5_valid", 64'(vec_valid), 64'd0);
      @(posedge clk);
      #1;
      send_vec5(40'hA1A2A3A4A5);
      @(negedge clk);
      check("t5_reassembly", 64'(vec_data), 64'hA1A2A3A4A5);
      @(posedge clk);
      #1;
      drain();
    end

`ifdef BDD_VEC_TAG_EN
    // Tag wrap with continuous popping; a discarded vector consumes no tag
    vec_ready = 1'b1;
    for (int k = 0; k < 258; k++) begin
      if (k == 100) send_len(3, 8'hE0);
      send_vec5({8'(k), 8'h11, 8'h22, 8'h33, 8'(k)});
    end
    vec_ready = 1'b0;
    drain();
`endif

    // Random traffic with occasional flush/reset and varying backpressure
    for (int c = 0; c < 3000; c++) begin
      if (pend.size() == 0) begin
        len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 8)) : N_FEAT;
        for (int i = 0; i < len; i++) begin
          rb = 8'($urandom());
          pend.push_back(rb);
        end
      end
      s_valid   = ($urandom_range(0, 3) != 0);
      s_data    = pend[0];
      s_last    = (pend.size() == 1);
      vec_ready = ((c / 400) % 2 == 1) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 149) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      @(negedge clk);
      if (s_valid && s_ready === 1'b1 && !flush && !rst) pend.delete(0);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    flush   = 1'b0;
    rst     = 1'b0;
    drain();
    @(negedge clk);
    check("final_empty", 64'(level), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bdd_feature_loader.md
Name: bdd_feature_loader

Overview:
Upstream stage of the BDD traversal engine.
- Accepts feature bytes on a valid/ready byte stream and assembles them into 5-feature vectors (a1..a5, 8 bit each).
- Buffers complete vectors in a small FIFO.
- Presents one vector at a time to the traversal engine over a valid/ready handshake. The engine consumes a vector when it starts a tree walk.

Parameters:
FEAT_W, 8, width of one feature/coefficient (matches node-memory coefficient width)
N_FEAT, 5, features per vector (a1..a5)
DEPTH, 4, FIFO depth in vectors; power of 2, >= 2

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  synchronous clear of FIFO and assembly state
s_valid  in  1  input byte valid
s_data  in  FEAT_W  feature byte; first byte = a1
s_last  in  1  marks final byte of a vector
s_ready  out  1  loader accepts byte this cycle
vec_valid  out  1  head vector available
vec_data  out  N_FEAT*FEAT_W  head vector; a1 in MSBs, a5 in LSBs
vec_ready  in  1  engine takes head vector
err_len  out  1  one-cycle pulse: malformed vector discarded
level  out  $clog2(DEPTH)+1  vectors currently stored

Behaviour:
- Byte transfer occurs when s_valid && s_ready. Vector transfer occurs when vec_valid && vec_ready.
- Reset (rst=1 at an edge):
  - FIFO emptied, byte index = 0, state = FILL.
  - Outputs after that edge: vec_valid=0, level=0, err_len=0, s_ready=1, vec_data=0.
  - rst overrides everything, including mid-vector and mid-handshake.
- flush: same effect as rst, but lower priority than rst. A byte or vector presented in the flush cycle is dropped/not popped.
- Assembly FSM, states FILL and DROP:
  - FILL, byte accepted with idx < N_FEAT-1:
    - s_last=0: store byte at slot idx, idx++.
    - s_last=1 (short vector): discard partial vector, err_len=1 next cycle, idx=0, stay FILL.
  - FILL, byte accepted with idx == N_FEAT-1:
    - s_last=1: push the completed vector into the FIFO at this edge, idx=0.
    - s_last=0 (long vector): discard, err_len=1 next cycle, go to DROP.
  - DROP: every byte is accepted and discarded. A byte with s_last=1 returns the FSM to FILL with idx=0. No further err_len pulse.
- s_ready:
  - In DROP: always 1.
  - In FILL: 1 unless idx == N_FEAT-1 and level == DEPTH.
  - Registered/combinational from state only; never depends on vec_ready (no in-to-out combinational path).
  - Bytes of an incomplete vector are accepted even when the FIFO is full.
- FIFO:
  - Show-ahead. vec_data is the head entry whenever vec_valid=1; it is 0 when empty.
  - vec_valid = (level != 0).
- Latency: final byte accepted at edge N into an empty FIFO gives vec_valid=1 and valid vec_data after edge N (a 1-cycle-visible path).
- Simultaneous push and pop: level unchanged, head advances, the new vector is written to the tail.
  - With level==1, the pushed vector becomes head immediately after the edge.
  - At level==DEPTH no push is possible (s_ready=0 for the final byte), so wrap cannot overrun.
- Pointers: $clog2(DEPTH) bits, wrap naturally modulo DEPTH. level is a separate counter, range 0..DEPTH.
- vec_ready while vec_valid=0: ignored.
- vec_data must stay stable while vec_valid=1 and vec_ready=0.

Optional Feature:
BDD_VEC_TAG_EN.
- Defined:
  - Adds output vec_tag [7:0], the sequence number of the head vector.
  - An 8-bit tag counter increments on each FIFO push and wraps 255->0. The tag is stored alongside each vector.
  - Counter resets to 0 on rst and on flush.
  - Discarded vectors do not consume a tag.
  - The engine forwards the tag with its class result.
- Undefined: port and tag storage absent; behaviour otherwise identical.

Decomposition:
- Package bdd_pkg holds:
  - FEAT_W and N_FEAT constants.
  - VEC_W = N_FEAT*FEAT_W.
  - The feature-vector typedef.
  - The assembly-state enum (FILL, DROP).
  - The tag width.
- One sub-module: bdd_vec_fifo, a generic synchronous show-ahead FIFO (width, depth parameters; push, pop, level, flush).
- Assembly FSM and shift register live in bdd_feature_loader.

Test Plan:
1. Basic: after reset, send bytes 0x11,0x22,0x33,0x44,0x55 (last on 0x55), vec_ready=0 -> vec_valid=1 the cycle after the last byte, vec_data=0x1122334455, level=1, err_len never pulses.
2. Short/long vectors: send 3 bytes with s_last on the 3rd -> err_len single pulse, level stays 0. Then send 7 bytes with s_last on the 7th -> one err_len pulse after byte 5, DROP absorbs bytes 6-7. A following good vector 0x0102030405 is delivered intact.
3. Backpressure: vec_ready=0, stream 5 good vectors -> level reaches 4; s_ready=0 only on the 5th vector's final byte. Raise vec_ready for one cycle -> byte accepted, level stays 4, heads delivered in order 1..5.
4. Simultaneous push/pop at level=1: final byte accepted in the same cycle vec_ready=1 -> level=1, vec_data switches to the new vector next cycle.
5. Flush/reset mid-vector: after 2 bytes of a vector with level=2, assert flush one cycle -> level=0, vec_valid=0. Next 5-byte vector assembles from a1 correctly. Repeat with rst -> same result.
6. With BDD_VEC_TAG_EN: push 258 good vectors, popping continuously -> vec_tag sequence 0..255,0,1. A discarded short vector between them does not advance the tag.
